// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared widths, state encoding and duty arithmetic for the PWM fade controller
package pwm_ctrl_pkg;

    localparam int PWM_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_HOLD = 2'd2,
        ST_DOWN = 2'd3
    } ctrl_state_t;

    // period+1 encodes 100% duty, so a larger target is clamped to it
    function automatic logic [PWM_W-1:0] clamp_target(
        input logic [PWM_W-1:0] target,
        input logic [PWM_W-1:0] period
    );
        logic [PWM_W:0] full;
        full = {1'b0, period} + (PWM_W+1)'(1);
        return ({1'b0, target} > full) ? full[PWM_W-1:0] : target;
    endfunction

    function automatic logic [PWM_W-1:0] ramp_up_duty(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] stp,
        input logic [PWM_W-1:0] tgt
    );
        logic [PWM_W:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        return (sum > {1'b0, tgt}) ? tgt : sum[PWM_W-1:0];
    endfunction

    function automatic logic [PWM_W-1:0] ramp_down_duty(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] stp
    );
        return (cur > stp) ? (cur - stp) : '0;
    endfunction

endpackage

// File: rtl/pwm512_period.sv
// rtl/pwm512_period.sv - free-running period counter with duty compare; output high for duty clocks per period
module pwm512_period
    import pwm_ctrl_pkg::*;
#(
    parameter int sys_clk_freq = 100_000_000
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [PWM_W-1:0] duty,
    input  logic [PWM_W-1:0] pwm_period,
    output logic             pwm_512
);

    logic [PWM_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt <= '0;
        end else if (cnt >= pwm_period) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    assign pwm_512 = (cnt < duty);

    // clock frequency is carried for documentation of the instance only
    if (sys_clk_freq <= 0) begin : g_freq_unset
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - soft-start, hold and soft-stop duty sequencer driving one pwm512_period core
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_W       = 16
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              start,
    input  logic              abort,
    input  logic [PWM_W-1:0]  cfg_period,
    input  logic [PWM_W-1:0]  cfg_target,
    input  logic [PWM_W-1:0]  cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold,
    output logic [PWM_W-1:0]  duty,
    output logic [PWM_W-1:0]  pwm_period,
    output logic              pwm_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam int SCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_PERIODS - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [HOLD_W:0]   HOLD_ONE  = (HOLD_W+1)'(1);

    ctrl_state_t       st_q, st_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic [PWM_W-1:0]  per_q, per_d;
    logic [PWM_W-1:0]  tgt_q, tgt_d;
    logic [PWM_W-1:0]  stp_q, stp_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [PWM_W-1:0]  pcnt_q;
    logic              done_q, done_d;

    logic              bnd;
    logic              step_tick;
    logic [PWM_W-1:0]  up_duty;
    logic [PWM_W-1:0]  down_duty;
    logic [HOLD_W:0]   hcnt_inc;

    // shadows the core's counter on the same period register so bnd marks its wrap
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pcnt_q <= '0;
        end else if (bnd) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PWM_W'(1);
        end
    end

    assign bnd       = (pcnt_q >= per_q);
    assign step_tick = bnd && (scnt_q == SCNT_LAST);
    assign up_duty   = ramp_up_duty(duty_q, stp_q, tgt_q);
    assign down_duty = ramp_down_duty(duty_q, stp_q);
    assign hcnt_inc  = {1'b0, hcnt_q} + HOLD_ONE;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            st_q   <= ST_IDLE;
            duty_q <= '0;
            per_q  <= '0;
            tgt_q  <= '0;
            stp_q  <= '0;
            hold_q <= '0;
            hcnt_q <= '0;
            scnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            duty_q <= duty_d;
            per_q  <= per_d;
            tgt_q  <= tgt_d;
            stp_q  <= stp_d;
            hold_q <= hold_d;
            hcnt_q <= hcnt_d;
            scnt_q <= scnt_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        duty_d = duty_q;
        per_d  = per_q;
        tgt_d  = tgt_q;
        stp_d  = stp_q;
        hold_d = hold_q;
        hcnt_d = hcnt_q;
        scnt_d = scnt_q;
        done_d = 1'b0;

        if (abort) begin
            st_d   = ST_IDLE;
            duty_d = '0;
            hcnt_d = '0;
            scnt_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (start) begin
                        per_d  = cfg_period;
                        tgt_d  = clamp_target(cfg_target, cfg_period);
                        stp_d  = (cfg_step == '0) ? PWM_W'(1) : cfg_step;
                        hold_d = cfg_hold;
                        hcnt_d = '0;
                        scnt_d = '0;
                        st_d   = ST_UP;
                    end
                end
                ST_UP: begin
                    if (bnd) begin
                        scnt_d = step_tick ? '0 : scnt_q + SCNT_ONE;
                    end
                    if (step_tick) begin
                        duty_d = up_duty;
                        if (up_duty == tgt_q) begin
                            st_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bnd) begin
                        if (hcnt_inc >= {1'b0, hold_q}) begin
                            st_d   = ST_DOWN;
                            hcnt_d = '0;
                            scnt_d = '0;
                        end else begin
                            hcnt_d = hcnt_inc[HOLD_W-1:0];
                        end
                    end
                end
                ST_DOWN: begin
                    if (bnd) begin
                        scnt_d = step_tick ? '0 : scnt_q + SCNT_ONE;
                    end
                    if (step_tick) begin
                        duty_d = down_duty;
                        if (down_duty == '0) begin
                            st_d   = ST_IDLE;
                            done_d = 1'b1;
                        end
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    pwm512_period #(
        .sys_clk_freq(SYS_CLK_FREQ)
    ) u_core (
        .clk       (clk),
        .reset_p   (reset_p),
        .duty      (duty_q),
        .pwm_period(per_q),
        .pwm_512   (pwm_out)
    );

    assign duty       = duty_q;
    assign pwm_period = per_q;
    assign busy       = (st_q != ST_IDLE);
    assign done       = done_q;
    assign state      = st_q;

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequences a single-channel PWM through a soft-start ramp, a hold phase and a soft-stop ramp.
- Instantiates the team's `pwm512_period` core and drives its `duty` and `pwm_period` inputs.
- Applies every duty change only at a PWM period boundary, so no output pulse is ever truncated.
- Sits between the software-facing register block (start/abort/config) and the motor, LED or servo pin.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock in Hz. Informational only; passed through to the core.
- STEP_PERIODS, 4, number of PWM periods per ramp step (≥1).
- HOLD_W, 16, width of the hold-count input.

Ports:
- clk  in  1  system clock, rising edge.
- reset_p  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- abort  in  1  forces an immediate return to IDLE.
- cfg_period  in  21  PWM period; the counter wraps after cfg_period+1 clocks.
- cfg_target  in  21  hold-phase duty.
- cfg_step  in  21  duty increment/decrement per step.
- cfg_hold  in  HOLD_W  number of PWM periods to stay in HOLD.
- duty  out  21  current duty driven to the core.
- pwm_period  out  21  latched period driven to the core.
- pwm_out  out  1  PWM output from the core.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- state  out  2  IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.

Behaviour:
- Reset (async, reset_p=1):
  - state=IDLE, duty=0, pwm_period=0, busy=0, done=0, pwm_out=0.
  - All internal counters cleared.
- Boundary tracker:
  - pcnt, 21 bits, follows the core's update rule exactly: if pcnt>=pwm_period then 0, else pcnt+1.
  - pcnt uses the same pwm_period register as the core, so the two stay in lockstep.
  - bnd is a pulse in the cycle where pcnt wraps to 0.
  - scnt counts bnd pulses 0..STEP_PERIODS-1; step_tick is bnd when scnt==STEP_PERIODS-1.
- Start (IDLE, start=1, abort=0) — all of the following take effect on the next clock:
  - Latch pwm_period<=cfg_period.
  - Latch tgt<=min(cfg_target, cfg_period+1); cfg_period+1 means 100% duty.
  - Latch stp<=(cfg_step==0 ? 1 : cfg_step).
  - Latch hold<=cfg_hold.
  - Clear scnt; go to RAMP_UP with duty still 0.
  - start in any other state is ignored.
- RAMP_UP:
  - On step_tick: duty<=min(duty+stp, tgt), with the sum computed at 22 bits (no wrap).
  - When the new duty equals tgt, go to HOLD.
  - If tgt==0, go to HOLD on the first step_tick.
- HOLD:
  - Counts bnd pulses; after hold bnd pulses, go to RAMP_DOWN.
  - hold==0 → go to RAMP_DOWN on the first bnd.
  - Clear scnt on exit.
- RAMP_DOWN:
  - On step_tick: duty<=(duty>stp) ? duty-stp : 0 (saturating).
  - When the new duty is 0, go to IDLE and pulse done for one cycle.
- Abort (any state):
  - Next clock: state=IDLE, duty=0, counters cleared, no done pulse.
  - pwm_period keeps its value.
  - abort and start in the same cycle: abort wins.
- cfg_* changes while busy have no effect until the next start.
- The duty register changes only in a bnd cycle (or on abort/reset), so the core compares against the new duty from the first clock of the next period.
- Latency: start → first nonzero duty = STEP_PERIODS full periods plus alignment to the first bnd.
- Reset mid-sequence: everything returns to reset values immediately; the next start behaves as from power-up.

Decomposition:
- Shared package `pwm_ctrl_pkg`:
  - State encoding constants ST_IDLE, ST_UP, ST_HOLD, ST_DOWN.
  - Duty/period width constant PWM_W=21.
- Sub-module: one instance of the existing `pwm512_period`.
  - Connections: duty, pwm_period and pwm_512→pwm_out; sys_clk_freq←SYS_CLK_FREQ.
- Boundary tracker and FSM stay inline in this module.

Test Plan:
1. Normal sequence. Stimulus: STEP_PERIODS=1, cfg_period=9, cfg_target=6, cfg_step=2, cfg_hold=3, start. Required:
   - Duty steps 0→2→4→6 at successive 10-clock boundaries, then 3 periods at 6.
   - Ramp down 4→2→0, then done pulse; busy falls in the same cycle as done.
   - pwm_out high for exactly duty clocks in each period.
2. Clamp and step-0. Stimulus: cfg_period=9, cfg_target=50, cfg_step=0. Required:
   - tgt=10, steps of 1.
   - pwm_out continuously 1 during HOLD.
3. Abort mid-ramp. Stimulus: abort during RAMP_UP at duty=4. Required:
   - Next cycle: duty=0, state=0, no done pulse.
   - A following start replays test 1 exactly.
4. Start ignored and start/abort collision. Stimulus: start pulsed in HOLD; start+abort together in IDLE. Required:
   - start in HOLD does not change the sequence.
   - Collision leaves the block in IDLE with busy=0.
5. Reset mid-sequence. Stimulus: assert reset_p asynchronously (between clock edges) during RAMP_DOWN. Required:
   - Outputs go to 0 immediately.
   - After release, start produces an identical sequence.
6. Saturation and hold=0. Stimulus: cfg_period=9, cfg_target=5, cfg_step=4, cfg_hold=0. Required:
   - Duty 0→4→5.
   - RAMP_DOWN is entered at the first boundary after duty reaches 5.
   - Ramp down 5→1→0, then done.
